// File: rtl/inst_rom_loader_pkg.sv
// Shared types and defaults for the instruction ROM loader slice.
// Holds the loader FSM state encoding and the default fetch geometry.
package inst_rom_loader_pkg;

   localparam int unsigned DEF_ADDR_W   = 10;
   localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_RUN  = 2'd2
   } ld_state_t;

endpackage

// File: rtl/inst_rom_loader_ram.sv
// Instruction word RAM: one synchronous write port, one asynchronous read port.
// Contents are never reset; a load simply overwrites the words it covers.
module inst_rom_loader_ram
   import inst_rom_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [31:0]       i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [31:0]       o_rdata
);

   localparam int unsigned MEM_WORDS = 2 ** ADDR_W;

   logic [31:0] r_mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch responder for the core's instruction port, backed by a word RAM that is
// filled from a big-endian byte stream while the core is held in reset.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rom_ce_i,
   input  logic [31:0]     rom_addr_i,
   output logic [31:0]     rom_data_o,
   input  logic            ld_start_i,
   input  logic [ADDR_W:0] ld_len_i,
   input  logic            ld_valid_i,
   input  logic [7:0]      ld_data_i,
   output logic            ld_ready_o,
   output logic            cpu_rst_o,
   output logic            ld_done_o,
   output logic            ld_err_o
);

   ld_state_t       r_state;
   ld_state_t       w_state_nxt;
   logic [1:0]      r_byte_cnt;
   logic [ADDR_W:0] r_word_cnt;
   logic [ADDR_W:0] r_len;
   logic [23:0]     r_shift;
   logic            r_err;

   logic            w_accept;
   logic            w_word_we;
   logic            w_last;
   logic            w_len_zero;
   logic            w_len_bad;
   logic            w_start_seen;
   logic            w_in_range;
   logic [31:0]     w_rdata;
   logic            w_unused_addr_lsb;

   assign w_accept     = (r_state == LD_LOAD) && ld_valid_i;
   assign w_word_we    = w_accept && (r_byte_cnt == 2'd3);
   assign w_last       = ((r_word_cnt + (ADDR_W + 1)'(1)) == r_len);
   assign w_len_zero   = (ld_len_i == '0);
   // Lengths above MEM_WORDS have the top bit set plus any lower bit.
   assign w_len_bad    = ld_len_i[ADDR_W] && (ld_len_i[ADDR_W-1:0] != '0);
   assign w_start_seen = ld_start_i && (r_state != LD_LOAD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= LD_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ld_ready_o  = 1'b0;
      ld_done_o   = 1'b0;
      case (r_state)
         LD_IDLE, LD_RUN: begin
            if (ld_start_i && !w_len_bad) begin
               w_state_nxt = w_len_zero ? LD_RUN : LD_LOAD;
            end
         end
         LD_LOAD: begin
            ld_ready_o = 1'b1;
            if (w_word_we && w_last) begin
               w_state_nxt = LD_RUN;
               ld_done_o   = 1'b1;
            end
         end
         default: w_state_nxt = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_byte_cnt <= '0;
         r_word_cnt <= '0;
         r_len      <= '0;
         r_shift    <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_start_seen) begin
            if (w_len_bad) begin
               r_err <= 1'b1;
            end else begin
               r_err      <= 1'b0;
               r_len      <= ld_len_i;
               r_word_cnt <= '0;
               r_byte_cnt <= '0;
            end
         end
         if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], ld_data_i};
            if (w_word_we) begin
               r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
            end
         end
      end
   end

   inst_rom_loader_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_word_we),
      .i_waddr (r_word_cnt[ADDR_W-1:0]),
      .i_wdata ({r_shift, ld_data_i}),
      .i_raddr (rom_addr_i[ADDR_W+1:2]),
      .o_rdata (w_rdata)
   );

   // Fetch stays combinational because the core has no wait input.
   assign w_in_range        = (rom_addr_i[31:ADDR_W+2] == '0);
   assign w_unused_addr_lsb = ^rom_addr_i[1:0];
   assign rom_data_o        = (rom_ce_i && (r_state != LD_LOAD) && w_in_range) ? w_rdata : NOP_WORD;

   assign cpu_rst_o = (r_state != LD_RUN);
   assign ld_err_o  = r_err;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed scoreboard bench: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_inst_rom_loader;

   localparam int unsigned ADDR_W = 10;

   localparam int S_DATA   = 0;
   localparam int S_CPURST = 1;
   localparam int S_READY  = 2;
   localparam int S_DONE   = 3;
   localparam int S_ERR    = 4;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            rom_ce_i;
   logic [31:0]     rom_addr_i;
   logic [31:0]     rom_data_o;
   logic            ld_start_i;
   logic [ADDR_W:0] ld_len_i;
   logic            ld_valid_i;
   logic [7:0]      ld_data_i;
   logic            ld_ready_o;
   logic            cpu_rst_o;
   logic            ld_done_o;
   logic            ld_err_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   inst_rom_loader #(
      .ADDR_W   (ADDR_W),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_ce_i   (rom_ce_i),
      .rom_addr_i (rom_addr_i),
      .rom_data_o (rom_data_o),
      .ld_start_i (ld_start_i),
      .ld_len_i   (ld_len_i),
      .ld_valid_i (ld_valid_i),
      .ld_data_i  (ld_data_i),
      .ld_ready_o (ld_ready_o),
      .cpu_rst_o  (cpu_rst_o),
      .ld_done_o  (ld_done_o),
      .ld_err_o   (ld_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_DATA:   return rom_data_o;
         S_CPURST: return {31'd0, cpu_rst_o};
         S_READY:  return {31'd0, ld_ready_o};
         S_DONE:   return {31'd0, ld_done_o};
         default:  return {31'd0, ld_err_o};
      endcase
   endfunction

   // Monitor: every queued expectation belongs to the current cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         logic [31:0] a;
         e = exp_q.pop_front();
         a = actual(e.sig);
         n_checks++;
         if (a !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.exp, $time);
         end
      end
   end

   task automatic push(input string name, input int sig, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cyc(input logic [ADDR_W:0] len);
      cyc();
      ld_start_i = 1'b1;
      ld_len_i   = len;
      ld_valid_i = 1'b0;
      rom_ce_i   = 1'b0;
   endtask

   task automatic byte_cyc(input logic v, input logic [7:0] d, input logic done_exp,
                           input logic st, input logic [ADDR_W:0] st_len);
      cyc();
      ld_start_i = st;
      ld_len_i   = st_len;
      ld_valid_i = v;
      ld_data_i  = d;
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h0;
      push("load_ready", S_READY, 32'd1);
      push("load_cpu_rst", S_CPURST, 32'd1);
      push("load_done", S_DONE, {31'd0, done_exp});
      push("load_fetch_gated", S_DATA, 32'h0);
   endtask

   task automatic fetch_cyc(input string name, input logic ce, input logic [31:0] addr,
                            input logic [31:0] exp);
      cyc();
      ld_start_i = 1'b0;
      ld_valid_i = 1'b0;
      rom_ce_i   = ce;
      rom_addr_i = addr;
      push(name, S_DATA, exp);
   endtask

   initial begin
      rst        = 1'b0;
      rom_ce_i   = 1'b0;
      rom_addr_i = '0;
      ld_start_i = 1'b0;
      ld_len_i   = '0;
      ld_valid_i = 1'b0;
      ld_data_i  = '0;

      // 1) reset values, then load two words
      cyc();
      cyc();
      push("rst_cpu_rst", S_CPURST, 32'd1);
      push("rst_ready", S_READY, 32'd0);
      push("rst_done", S_DONE, 32'd0);
      push("rst_err", S_ERR, 32'd0);
      push("rst_data", S_DATA, 32'h0);
      cyc();
      rst = 1'b1;
      start_cyc(11'd2);
      push("idle_ready", S_READY, 32'd0);
      push("idle_cpu_rst", S_CPURST, 32'd1);
      byte_cyc(1'b1, 8'h12, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h34, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h56, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h78, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h9A, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'hBC, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'hDE, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'hF0, 1'b1, 1'b0, '0);
      fetch_cyc("t1_ram0", 1'b1, 32'h0, 32'h1234_5678);
      push("t1_cpu_rst_low", S_CPURST, 32'd0);
      push("t1_ready_low", S_READY, 32'd0);
      push("t1_done_low", S_DONE, 32'd0);

      // 2) fetches in RUN
      fetch_cyc("t2_ram1", 1'b1, 32'h4, 32'h9ABC_DEF0);
      fetch_cyc("t2_lsb_ignored", 1'b1, 32'h7, 32'h9ABC_DEF0);
      fetch_cyc("t2_ce_off", 1'b0, 32'h4, 32'h0);

      // 3) out-of-range
      fetch_cyc("t3_oor_4k", 1'b1, 32'h0000_1000, 32'h0);
      fetch_cyc("t3_oor_high", 1'b1, 32'h8000_0004, 32'h0);

      // 4) rejected length from IDLE, then boot existing contents
      cyc();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      start_cyc(11'd1025);
      fetch_cyc("t4_idle_fetch", 1'b1, 32'h4, 32'h9ABC_DEF0);
      push("t4_err_set", S_ERR, 32'd1);
      push("t4_cpu_rst_held", S_CPURST, 32'd1);
      push("t4_ready_low", S_READY, 32'd0);
      start_cyc(11'd0);
      push("t4_err_still", S_ERR, 32'd1);
      fetch_cyc("t4_boot_fetch", 1'b1, 32'h0, 32'h1234_5678);
      push("t4_err_clear", S_ERR, 32'd0);
      push("t4_cpu_rst_low", S_CPURST, 32'd0);

      // 5) reload with gappy valid and an ignored mid-load start
      start_cyc(11'd1);
      push("t5_run_cpu_rst", S_CPURST, 32'd0);
      byte_cyc(1'b0, 8'hFF, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'hA1, 1'b0, 1'b0, '0);
      byte_cyc(1'b0, 8'hEE, 1'b0, 1'b0, '0);
      byte_cyc(1'b0, 8'hDD, 1'b0, 1'b1, 11'd3);
      byte_cyc(1'b1, 8'hB2, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'hC3, 1'b0, 1'b1, 11'd1025);
      byte_cyc(1'b0, 8'h77, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'hD4, 1'b1, 1'b0, '0);
      fetch_cyc("t5_ram0", 1'b1, 32'h0, 32'hA1B2_C3D4);
      push("t5_err_untouched", S_ERR, 32'd0);
      push("t5_cpu_rst_low", S_CPURST, 32'd0);
      fetch_cyc("t5_ram1_kept", 1'b1, 32'h4, 32'h9ABC_DEF0);

      // 6) reset mid-load, then a fresh single-word load
      start_cyc(11'd2);
      byte_cyc(1'b1, 8'h11, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h22, 1'b0, 1'b0, '0);
      cyc();
      rst        = 1'b0;
      ld_valid_i = 1'b0;
      push("t6_rst_ready", S_READY, 32'd0);
      push("t6_rst_cpu_rst", S_CPURST, 32'd1);
      push("t6_rst_done", S_DONE, 32'd0);
      cyc();
      rst = 1'b1;
      start_cyc(11'd1);
      byte_cyc(1'b1, 8'h55, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h66, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h77, 1'b0, 1'b0, '0);
      byte_cyc(1'b1, 8'h88, 1'b1, 1'b0, '0);
      fetch_cyc("t6_ram0", 1'b1, 32'h0, 32'h5566_7788);
      fetch_cyc("t6_ram1_kept", 1'b1, 32'h4, 32'h9ABC_DEF0);

      cyc();
      rom_ce_i = 1'b0;
      cyc();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
